// File: rtl/gshare_btb_predictor_if.sv
// Request/response/training bundle for gshare_btb_predictor.
// master: fetch/execute side; drives requests and training, observes responses and statistics.
// slave : predictor side.
interface gshare_btb_predictor_if #(
  parameter int unsigned PC_W   = 16,
  parameter int unsigned HIST_W = 8
);
  // Prediction request and registered response
  logic              pred_valid;
  logic [PC_W-1:0]   pred_pc;
  logic              resp_valid;
  logic              resp_taken;
  logic              resp_hit;
  logic [PC_W-1:0]   resp_target;
  logic [HIST_W-1:0] resp_history;
  // Resolved-branch training
  logic              train_valid;
  logic [PC_W-1:0]   train_pc;
  logic [HIST_W-1:0] train_history;
  logic              train_taken;
  logic [PC_W-1:0]   train_target;
  logic              train_mispredicted;
  // Saturating statistics
  logic [15:0]       stat_branches;
  logic [15:0]       stat_mispredicts;

  modport master (
    output pred_valid, pred_pc,
    output train_valid, train_pc, train_history, train_taken, train_target, train_mispredicted,
    input  resp_valid, resp_taken, resp_hit, resp_target, resp_history,
    input  stat_branches, stat_mispredicts
  );

  modport slave (
    input  pred_valid, pred_pc,
    input  train_valid, train_pc, train_history, train_taken, train_target, train_mispredicted,
    output resp_valid, resp_taken, resp_hit, resp_target, resp_history,
    output stat_branches, stat_mispredicts
  );
endinterface

// File: rtl/gshare_btb_predictor.sv
// gshare direction predictor with a direct-mapped BTB, speculative global history and
// mispredict recovery. Predictions return registered one cycle after the request.
// Ports:
//   CLK - clock, rising edge
//   RES - asynchronous active-high reset
//   bus - gshare_btb_predictor_if.slave: pred_* request, resp_* response,
//         train_* resolved-branch update, stat_* saturating counters
module gshare_btb_predictor #(
  parameter int unsigned PC_W      = 16,
  parameter int unsigned HIST_W    = 8,
  parameter int unsigned CTR_W     = 2,
  parameter int unsigned BTB_IDX_W = 4
) (
  input  logic                   CLK,
  input  logic                   RES,
  gshare_btb_predictor_if.slave  bus
);
  localparam int unsigned PhtDepth = 2 ** HIST_W;
  localparam int unsigned BtbDepth = 2 ** BTB_IDX_W;
  localparam int unsigned TagW     = PC_W - BTB_IDX_W;
  // Weakly not-taken: MSB clear, all other bits set
  localparam logic [CTR_W-1:0] CtrInit = {1'b0, {(CTR_W-1){1'b1}}};

  logic [HIST_W-1:0] ghr_q, ghr_d;
  logic [CTR_W-1:0]  pht_q [PhtDepth];
  logic [CTR_W-1:0]  pht_d [PhtDepth];
  logic [BtbDepth-1:0] btb_valid_q, btb_valid_d;
  logic [TagW-1:0]   btb_tag_q [BtbDepth];
  logic [TagW-1:0]   btb_tag_d [BtbDepth];
  logic [PC_W-1:0]   btb_target_q [BtbDepth];
  logic [PC_W-1:0]   btb_target_d [BtbDepth];
  logic [15:0]       stat_branches_q, stat_branches_d;
  logic [15:0]       stat_mispredicts_q, stat_mispredicts_d;
  logic              resp_valid_q, resp_valid_d;
  logic              resp_taken_q, resp_taken_d;
  logic              resp_hit_q, resp_hit_d;
  logic [PC_W-1:0]   resp_target_q, resp_target_d;
  logic [HIST_W-1:0] resp_history_q, resp_history_d;

  // Predict path: reads pre-edge tables only
  logic [HIST_W-1:0]    pred_idx;
  logic [BTB_IDX_W-1:0] pred_btb_idx;
  logic [TagW-1:0]      pred_tag;
  logic                 pred_hit;
  logic                 pred_taken;
  logic [PC_W-1:0]      pred_target;

  assign pred_idx     = bus.pred_pc[HIST_W-1:0] ^ ghr_q;
  assign pred_btb_idx = bus.pred_pc[BTB_IDX_W-1:0];
  assign pred_tag     = bus.pred_pc[PC_W-1:BTB_IDX_W];
  assign pred_hit     = btb_valid_q[pred_btb_idx] && (btb_tag_q[pred_btb_idx] == pred_tag);
  assign pred_taken   = pred_hit && pht_q[pred_idx][CTR_W-1];
  assign pred_target  = pred_taken ? btb_target_q[pred_btb_idx] : bus.pred_pc + PC_W'(1);

  // Train path
  logic [HIST_W-1:0]    train_idx;
  logic [BTB_IDX_W-1:0] train_btb_idx;
  logic [CTR_W-1:0]     train_ctr;

  assign train_idx     = bus.train_pc[HIST_W-1:0] ^ bus.train_history;
  assign train_btb_idx = bus.train_pc[BTB_IDX_W-1:0];
  assign train_ctr     = pht_q[train_idx];

  always_comb begin
    ghr_d              = ghr_q;
    pht_d              = pht_q;
    btb_valid_d        = btb_valid_q;
    btb_tag_d          = btb_tag_q;
    btb_target_d       = btb_target_q;
    stat_branches_d    = stat_branches_q;
    stat_mispredicts_d = stat_mispredicts_q;
    resp_valid_d       = bus.pred_valid;
    resp_taken_d       = resp_taken_q;
    resp_hit_d         = resp_hit_q;
    resp_target_d      = resp_target_q;
    resp_history_d     = resp_history_q;

    if (bus.pred_valid) begin
      resp_taken_d   = pred_taken;
      resp_hit_d     = pred_hit;
      resp_target_d  = pred_target;
      resp_history_d = ghr_q;
      ghr_d          = {ghr_q[HIST_W-2:0], pred_taken};
    end

    if (bus.train_valid) begin
      if (bus.train_taken) begin
        if (train_ctr != '1) pht_d[train_idx] = train_ctr + CTR_W'(1);
        btb_valid_d[train_btb_idx]  = 1'b1;
        btb_tag_d[train_btb_idx]    = bus.train_pc[PC_W-1:BTB_IDX_W];
        btb_target_d[train_btb_idx] = bus.train_target;
      end else if (train_ctr != '0) begin
        pht_d[train_idx] = train_ctr - CTR_W'(1);
      end
      if (stat_branches_q != '1) stat_branches_d = stat_branches_q + 16'd1;
      if (bus.train_mispredicted) begin
        if (stat_mispredicts_q != '1) stat_mispredicts_d = stat_mispredicts_q + 16'd1;
        // Recovery wins over the speculative shift of a same-cycle prediction
        ghr_d = {bus.train_history[HIST_W-2:0], bus.train_taken};
      end
    end
  end

  always_ff @(posedge CLK or posedge RES) begin
    if (RES) begin
      ghr_q              <= '0;
      btb_valid_q        <= '0;
      stat_branches_q    <= '0;
      stat_mispredicts_q <= '0;
      resp_valid_q       <= 1'b0;
      resp_taken_q       <= 1'b0;
      resp_hit_q         <= 1'b0;
      resp_target_q      <= '0;
      resp_history_q     <= '0;
      for (int i = 0; i < PhtDepth; i++) pht_q[i] <= CtrInit;
      for (int i = 0; i < BtbDepth; i++) begin
        btb_tag_q[i]    <= '0;
        btb_target_q[i] <= '0;
      end
    end else begin
      ghr_q              <= ghr_d;
      pht_q              <= pht_d;
      btb_valid_q        <= btb_valid_d;
      btb_tag_q          <= btb_tag_d;
      btb_target_q       <= btb_target_d;
      stat_branches_q    <= stat_branches_d;
      stat_mispredicts_q <= stat_mispredicts_d;
      resp_valid_q       <= resp_valid_d;
      resp_taken_q       <= resp_taken_d;
      resp_hit_q         <= resp_hit_d;
      resp_target_q      <= resp_target_d;
      resp_history_q     <= resp_history_d;
    end
  end

  assign bus.resp_valid       = resp_valid_q;
  assign bus.resp_taken       = resp_taken_q;
  assign bus.resp_hit         = resp_hit_q;
  assign bus.resp_target      = resp_target_q;
  assign bus.resp_history     = resp_history_q;
  assign bus.stat_branches    = stat_branches_q;
  assign bus.stat_mispredicts = stat_mispredicts_q;
endmodule

// File: tb/tb_gshare_btb_predictor.sv
// Self-checking bench for gshare_btb_predictor (PC_W=16, HIST_W=8, CTR_W=2, BTB_IDX_W=4).
// Driver changes inputs on the falling edge and pushes expected responses from a
// table-level reference model; a monitor pops and compares after each rising edge.
module tb_gshare_btb_predictor;
  logic clk = 1'b0;
  logic res = 1'b1;
  always #5 clk = ~clk;

  gshare_btb_predictor_if #(.PC_W(16), .HIST_W(8)) bus ();

  gshare_btb_predictor #(
    .PC_W      (16),
    .HIST_W    (8),
    .CTR_W     (2),
    .BTB_IDX_W (4)
  ) dut (
    .CLK (clk),
    .RES (res),
    .bus (bus)
  );

  typedef struct {
    int pc;
    int taken;
    int hit;
    int target;
    int hist;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;

  // Reference model state
  int m_ghr;
  int m_pht[256];
  bit m_bv[16];
  int m_btag[16];
  int m_btgt[16];
  int m_sb;
  int m_sm;

  task automatic model_reset();
    m_ghr = 0;
    for (int i = 0; i < 256; i++) m_pht[i] = 1;
    for (int i = 0; i < 16; i++) begin
      m_bv[i]   = 1'b0;
      m_btag[i] = 0;
      m_btgt[i] = 0;
    end
    m_sb = 0;
    m_sm = 0;
  endtask

  task automatic check(input string name, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic drive_idle();
    bus.pred_valid         = 1'b0;
    bus.pred_pc            = '0;
    bus.train_valid        = 1'b0;
    bus.train_pc           = '0;
    bus.train_history      = '0;
    bus.train_taken        = 1'b0;
    bus.train_target       = '0;
    bus.train_mispredicted = 1'b0;
  endtask

  // One cycle of stimulus; the model is advanced exactly as the edge will advance the DUT
  task automatic step(input bit pv, input int ppc, input bit tv, input int tpc, input int th,
                      input bit tt, input int ttgt, input bit tm, input bit chk);
    exp_t e;
    int   idx;
    int   bi;
    @(negedge clk);
    if (chk) begin
      check("stat_branches", int'(bus.stat_branches), m_sb);
      check("stat_mispredicts", int'(bus.stat_mispredicts), m_sm);
    end
    bus.pred_valid         = pv;
    bus.pred_pc            = ppc[15:0];
    bus.train_valid        = tv;
    bus.train_pc           = tpc[15:0];
    bus.train_history      = th[7:0];
    bus.train_taken        = tt;
    bus.train_target       = ttgt[15:0];
    bus.train_mispredicted = tm;
    e = '{pc: 0, taken: 0, hit: 0, target: 0, hist: 0};
    if (pv) begin
      idx      = (ppc ^ m_ghr) % 256;
      bi       = ppc % 16;
      e.pc     = ppc;
      e.hit    = (m_bv[bi] && m_btag[bi] == ppc / 16) ? 1 : 0;
      e.taken  = (e.hit == 1 && m_pht[idx] >= 2) ? 1 : 0;
      e.target = (e.taken == 1) ? m_btgt[bi] : (ppc + 1) % 65536;
      e.hist   = m_ghr;
      q.push_back(e);
    end
    if (tv) begin
      idx = (tpc ^ th) % 256;
      if (tt) begin
        if (m_pht[idx] < 3) m_pht[idx]++;
        bi         = tpc % 16;
        m_bv[bi]   = 1'b1;
        m_btag[bi] = tpc / 16;
        m_btgt[bi] = ttgt;
      end else if (m_pht[idx] > 0) begin
        m_pht[idx]--;
      end
      if (m_sb < 65535) m_sb++;
      if (tm && m_sm < 65535) m_sm++;
    end
    if (pv) m_ghr = (m_ghr * 2 + e.taken) % 256;
    if (tv && tm) m_ghr = (th * 2 + int'(tt)) % 256;
  endtask

  task automatic pred(input int pc);
    step(1'b1, pc, 1'b0, 0, 0, 1'b0, 0, 1'b0, 1'b1);
  endtask

  task automatic trn(input int pc, input int h, input bit t, input int tgt, input bit m);
    step(1'b0, 0, 1'b1, pc, h, t, tgt, m, 1'b1);
  endtask

  task automatic idle();
    step(1'b0, 0, 1'b0, 0, 0, 1'b0, 0, 1'b0, 1'b1);
  endtask

  task automatic check_cleared(input string tag);
    check({tag, " resp_valid"}, int'(bus.resp_valid), 0);
    check({tag, " resp_taken"}, int'(bus.resp_taken), 0);
    check({tag, " resp_hit"}, int'(bus.resp_hit), 0);
    check({tag, " resp_target"}, int'(bus.resp_target), 0);
    check({tag, " resp_history"}, int'(bus.resp_history), 0);
    check({tag, " stat_branches"}, int'(bus.stat_branches), 0);
    check({tag, " stat_mispredicts"}, int'(bus.stat_mispredicts), 0);
  endtask

  // Monitor: every presented response must match the oldest expectation
  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (!res) begin
        if (bus.resp_valid) begin
          total++;
          if (q.size() == 0) begin
            bad++;
            $display("FAIL resp_unexpected: got resp_valid=1 expected no response");
          end else begin
            exp_t e;
            e = q.pop_front();
            if (int'(bus.resp_taken) != e.taken || int'(bus.resp_hit) != e.hit ||
                int'(bus.resp_target) != e.target || int'(bus.resp_history) != e.hist) begin
              bad++;
              $display("FAIL resp pc=0x%0h: got taken=%0d hit=%0d target=0x%0h hist=0x%0h expected taken=%0d hit=%0d target=0x%0h hist=0x%0h",
                       e.pc, bus.resp_taken, bus.resp_hit, bus.resp_target, bus.resp_history,
                       e.taken, e.hit, e.target, e.hist);
            end
          end
        end else if (q.size() != 0) begin
          total++;
          bad++;
          $display("FAIL resp_missing: got resp_valid=0 expected response for pc=0x%0h",
                   q[0].pc);
          q.delete();
        end
      end
    end
  end

  initial begin
    drive_idle();
    model_reset();
    repeat (3) @(negedge clk);
    res = 1'b0;
    #1;
    check_cleared("reset");

    // Reset state prediction
    pred(16'h0010);

    // Train to taken through a different history
    trn(16'h0020, 0, 1'b1, 16'h0008, 1'b1);
    pred(16'h0020);
    trn(16'h0020, 1, 1'b1, 16'h0008, 1'b0);
    trn(16'h0020, 1, 1'b1, 16'h0008, 1'b0);
    trn(16'h0020, 0, 1'b1, 16'h0008, 1'b1);
    pred(16'h0020);
    pred(16'h0020);

    // Counter floor: five decrements then one increment must stay not-taken
    repeat (5) trn(16'h0031, 1, 1'b0, 0, 1'b0);
    trn(16'h0031, 1, 1'b1, 16'h0055, 1'b0);
    trn(16'h0031, 0, 1'b1, 16'h0055, 1'b1);
    pred(16'h0031);

    // Same-cycle predict and mispredicted train
    step(1'b1, 16'h0020, 1'b1, 16'h0020, 8'h7F, 1'b0, 0, 1'b1, 1'b1);
    pred(16'h0002);

    // PC wrap and BTB aliasing
    pred(16'hFFFF);
    trn(16'h0013, 0, 1'b1, 16'h0100, 1'b0);
    trn(16'h0023, 0, 1'b1, 16'h0200, 1'b0);
    pred(16'h0013);
    pred(16'h0023);

    // Saturate the PHT entry at 0x44, then reset mid-stream with requests in flight
    repeat (3) trn(16'h0044, 0, 1'b1, 16'h0099, 1'b0);
    pred(16'h0040);
    pred(16'h0041);
    @(posedge clk);
    #1;
    res = 1'b1;
    drive_idle();
    q.delete();
    model_reset();
    #1;
    check_cleared("async_reset");
    repeat (2) @(posedge clk);
    @(negedge clk);
    res = 1'b0;

    // PHT must be back to weakly not-taken
    trn(16'h0044, 0, 1'b1, 16'h0099, 1'b1);
    trn(16'h0044, 0, 1'b0, 0, 1'b1);
    pred(16'h0044);

    // Randomized mix of predictions and trains, including same-cycle overlap
    for (int i = 0; i < 400; i++) begin
      int  ppc;
      int  tpc;
      bit  pv;
      bit  tv;
      ppc = int'($urandom_range(0, 3)) * 16 + int'($urandom_range(0, 15));
      tpc = int'($urandom_range(0, 3)) * 16 + int'($urandom_range(0, 15));
      if ($urandom_range(0, 7) == 0) ppc = 16'hFFF0 + int'($urandom_range(0, 15));
      pv = ($urandom_range(0, 3) != 0);
      tv = ($urandom_range(0, 1) != 0);
      step(pv, ppc, tv, tpc, int'($urandom_range(0, 3)), ($urandom_range(0, 3) != 0),
           int'($urandom_range(0, 65535)), ($urandom_range(0, 2) == 0), 1'b1);
    end

    // Statistics saturation
    for (int i = 0; i < 32'h10005; i++) begin
      step(1'b0, 0, 1'b1, 16'h0050, 0, 1'b0, 0, 1'b1, 1'b0);
    end
    idle();
    check("stat_branches_sat", int'(bus.stat_branches), 16'hFFFF);
    check("stat_mispredicts_sat", int'(bus.stat_mispredicts), 16'hFFFF);
    pred(16'h0050);
    repeat (3) idle();

    check("queue_drained", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
